// File: rtl/fetch_realign.sv
// Fetch realigner: splits an I$ fetch word into compressed/32-bit instruction slots,
// stitching 32-bit instructions that straddle words. Optional macro FETCH_REALIGN_STATS_EN.
module fetch_realign #(
  parameter int unsigned FETCH_WIDTH = 32
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              flush_i,
  input  logic                              data_valid_i,
  input  logic [FETCH_WIDTH-1:0]            data_i,
  input  logic [63:0]                       address_i,
  input  logic                              ex_i,
  output logic                              data_ready_o,
  input  logic                              ready_i,
  output logic [FETCH_WIDTH/16-1:0][31:0]   instr_o,
  output logic [FETCH_WIDTH/16-1:0][63:0]   addr_o,
  output logic [FETCH_WIDTH/16-1:0]         valid_o,
  output logic                              ex_o,
  output logic [31:0]                       straddle_cnt_o
);
  localparam int unsigned N   = FETCH_WIDTH / 16;
  localparam int unsigned LOG = $clog2(N);

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] addr;
    logic        vld;
  } slot_t;

  logic [N-1:0][15:0] hw;
  slot_t [N-1:0]      slot;
  logic               fire, cont;
  logic               save;
  logic [15:0]        save_instr;
  logic [63:0]        save_addr;
  logic               unaligned_q;
  logic [15:0]        unaligned_instr_q;
  logic [63:0]        unaligned_addr_q;
  int                 p, k;

  assign hw           = data_i;
  assign data_ready_o = ready_i & ~rst_i & ~flush_i;
  assign fire         = data_valid_i & data_ready_o;
  assign cont         = unaligned_q & (address_i == unaligned_addr_q + 64'd2);

  // Walk halfwords from the start position, emitting slots packed from slot 0.
  always_comb begin
    slot       = '0;
    save       = 1'b0;
    save_instr = '0;
    save_addr  = '0;
    ex_o       = 1'b0;
    p          = 0;
    k          = 0;
    if (fire) begin
      if (ex_i) begin
        slot[0].vld  = 1'b1;
        slot[0].addr = address_i;
        ex_o         = 1'b1;
      end else begin
        if (cont) begin
          slot[0].vld   = 1'b1;
          slot[0].instr = {hw[0], unaligned_instr_q};
          slot[0].addr  = unaligned_addr_q;
          p = 1;
          k = 1;
        end else begin
          p = int'(address_i[LOG:1]);
        end
        for (int i = 0; i < int'(N); i++) begin
          if (i == p && k < int'(N)) begin
            if (hw[i][1:0] != 2'b11) begin
              slot[k].vld   = 1'b1;
              slot[k].instr = {16'h0, hw[i]};
              slot[k].addr  = {address_i[63:LOG+1], LOG'(i), 1'b0};
              p = i + 1;
              k = k + 1;
            end else if (i + 1 < int'(N)) begin
              slot[k].vld   = 1'b1;
              slot[k].instr = {hw[(i+1)%N], hw[i]};
              slot[k].addr  = {address_i[63:LOG+1], LOG'(i), 1'b0};
              p = i + 2;
              k = k + 1;
            end else begin
              save       = 1'b1;
              save_instr = hw[i];
              save_addr  = {address_i[63:LOG+1], LOG'(i), 1'b0};
              p = int'(N);
            end
          end
        end
      end
    end
  end

  for (genvar g = 0; g < int'(N); g++) begin : g_slot
    assign instr_o[g] = slot[g].instr;
    assign addr_o[g]  = slot[g].addr;
    assign valid_o[g] = slot[g].vld;
  end

  // An exception fire never saves, so it also drops any pending halfword.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      unaligned_q       <= 1'b0;
      unaligned_instr_q <= '0;
      unaligned_addr_q  <= '0;
    end else if (fire) begin
      unaligned_q <= save;
      if (save) begin
        unaligned_instr_q <= save_instr;
        unaligned_addr_q  <= save_addr;
      end
    end
  end

`ifdef FETCH_REALIGN_STATS_EN
  logic [31:0] straddle_cnt_q;
  always_ff @(posedge clk_i) begin
    if (rst_i)
      straddle_cnt_q <= '0;
    else if (fire && cont && !ex_i && straddle_cnt_q != 32'hFFFF_FFFF)
      straddle_cnt_q <= straddle_cnt_q + 32'd1;
  end
  assign straddle_cnt_o = straddle_cnt_q;
`else
  assign straddle_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fetch_realign.sv
// Bench for fetch_realign (FETCH_WIDTH=32): directed plan steps then random traffic,
// checked against a halfword-stream reference model.
module tb_fetch_realign;
  logic              clk_i = 1'b0;
  logic              rst_i, flush_i, data_valid_i, ex_i, ready_i;
  logic [31:0]       data_i;
  logic [63:0]       address_i;
  logic              data_ready_o, ex_o;
  logic [1:0][31:0]  instr_o;
  logic [1:0][63:0]  addr_o;
  logic [1:0]        valid_o;
  logic [31:0]       straddle_cnt_o;

  int checks = 0, failures = 0;

  // reference state
  logic        mq = 1'b0;
  logic [15:0] mhw = '0;
  logic [63:0] maddr = '0;
  logic [31:0] mcnt = '0;

  // values captured at the last sample point
  logic [1:0]  cap_valid;
  logic [31:0] cap_i0, cap_i1;
  logic [63:0] cap_a0, cap_a1;
  logic        cap_ex;

  fetch_realign #(.FETCH_WIDTH(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .data_valid_i(data_valid_i),
    .data_i(data_i), .address_i(address_i), .ex_i(ex_i), .data_ready_o(data_ready_o),
    .ready_i(ready_i), .instr_o(instr_o), .addr_o(addr_o), .valid_o(valid_o),
    .ex_o(ex_o), .straddle_cnt_o(straddle_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive, sample combinational outputs mid-cycle, clock, check state.
  task automatic step(input logic dv, input logic [31:0] d, input logic [63:0] a,
                      input logic e, input logic rdy, input logic fl, input logic rs);
    logic [15:0] sh[$];
    logic [63:0] sa[$];
    logic [31:0] ei[$];
    logic [63:0] ea[$];
    logic        fire, cont, nq, eex;
    logic [15:0] nhw, h;
    logic [63:0] naddr, ha;
    logic [31:0] ncnt;
    logic [1:0]  ev;
    data_valid_i = dv; data_i = d; address_i = a; ex_i = e;
    ready_i = rdy; flush_i = fl; rst_i = rs;
    #4;
    fire = dv & rdy & ~rs & ~fl;
    nq = mq; nhw = mhw; naddr = maddr; ncnt = mcnt; eex = 1'b0;
    if (rs || fl) begin
      nq = 1'b0; nhw = '0; naddr = '0;
      if (rs) ncnt = '0;
    end else if (fire) begin
      cont = mq && (a == maddr + 64'd2);
      nq = 1'b0;
      if (e) begin
        ei.push_back(32'h0); ea.push_back(a); eex = 1'b1;
      end else begin
        if (cont) begin
          sh.push_back(mhw); sa.push_back(maddr);
          if (mcnt != 32'hFFFF_FFFF) ncnt = mcnt + 32'd1;
        end
        for (int j = (cont ? 0 : int'(a[1])); j < 2; j++) begin
          sh.push_back(d[16*j +: 16]);
          sa.push_back((a & ~64'h3) + 64'(2*j));
        end
        while (sh.size() > 0) begin
          h = sh.pop_front(); ha = sa.pop_front();
          if (h[1:0] != 2'b11) begin
            ei.push_back({16'h0, h}); ea.push_back(ha);
          end else if (sh.size() > 0) begin
            ei.push_back({sh.pop_front(), h}); ea.push_back(ha);
            void'(sa.pop_front());
          end else begin
            nq = 1'b1; nhw = h; naddr = ha;
          end
        end
      end
    end
    ev = '0;
    for (int s = 0; s < ei.size(); s++) ev[s] = 1'b1;
    chk("data_ready", 64'(data_ready_o), 64'(rdy & ~rs & ~fl));
    chk("valid", 64'(valid_o), 64'(ev));
    chk("ex", 64'(ex_o), 64'(eex));
    for (int s = 0; s < ei.size(); s++) begin
      chk($sformatf("instr%0d", s), 64'(instr_o[s]), 64'(ei[s]));
      chk($sformatf("addr%0d", s), addr_o[s], ea[s]);
    end
    cap_valid = valid_o; cap_ex = ex_o;
    cap_i0 = instr_o[0]; cap_i1 = instr_o[1];
    cap_a0 = addr_o[0];  cap_a1 = addr_o[1];
    @(posedge clk_i);
    #1;
    mq = nq; mhw = nhw; maddr = naddr;
`ifdef FETCH_REALIGN_STATS_EN
    mcnt = ncnt;
`else
    mcnt = '0;
`endif
    chk("unaligned_q", 64'(dut.unaligned_q), 64'(mq));
    chk("straddle_cnt", 64'(straddle_cnt_o), 64'(mcnt));
  endtask

  initial begin
    logic [31:0] rd;
    logic [63:0] ra;
    rst_i = 1'b1; flush_i = 1'b0; data_valid_i = 1'b0; ex_i = 1'b0; ready_i = 1'b0;
    data_i = '0; address_i = '0;
    @(posedge clk_i); #1;
    // reset
    step(0, 32'h0, 64'h0, 0, 1, 0, 1);
    chk("reset_uq", 64'(dut.unaligned_q), 64'h0);
    // two compressed
    step(1, 32'h4501_4581, 64'h8000_0000, 0, 1, 0, 0);
    chk("c2_valid", 64'(cap_valid), 64'h3);
    chk("c2_i0", 64'(cap_i0), 64'h4581);
    chk("c2_a1", cap_a1, 64'h8000_0002);
    // straddle
    step(1, 32'h0513_4581, 64'h1000, 0, 1, 0, 0);
    chk("st1_valid", 64'(cap_valid), 64'h1);
    step(1, 32'h0001_0000, 64'h1004, 0, 1, 0, 0);
    chk("st2_i0", 64'(cap_i0), 64'h513);
    chk("st2_a0", cap_a0, 64'h1002);
    chk("st2_i1", 64'(cap_i1), 64'h1);
    chk("st2_a1", cap_a1, 64'h1006);
    // discontinuity
    step(1, 32'h0513_4581, 64'h1000, 0, 1, 0, 0);
    step(1, 32'h4501_4581, 64'h2000, 0, 1, 0, 0);
    chk("disc_a0", cap_a0, 64'h2000);
    chk("disc_a1", cap_a1, 64'h2002);
    // unaligned entry then exception
    step(1, 32'h4581_FFFF, 64'h1002, 0, 1, 0, 0);
    chk("ua_valid", 64'(cap_valid), 64'h1);
    chk("ua_i0", 64'(cap_i0), 64'h4581);
    step(1, 32'h0513_4581, 64'h3000, 1, 1, 0, 0);
    chk("ex_flag", 64'(cap_ex), 64'h1);
    chk("ex_i0", 64'(cap_i0), 64'h0);
    chk("ex_a0", cap_a0, 64'h3000);
    // stall with saved halfword
    step(1, 32'h0513_4581, 64'h1000, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 32'h0001_0000, 64'h1004, 0, 0, 0, 0);
    step(1, 32'h0001_0000, 64'h1004, 0, 1, 0, 0);
    chk("stall_i0", 64'(cap_i0), 64'h513);
    // flush with valid
    step(1, 32'h0513_4581, 64'h1000, 0, 1, 0, 0);
    step(1, 32'h4501_4581, 64'h1004, 0, 1, 1, 0);
    chk("flush_valid", 64'(cap_valid), 64'h0);
    // reset mid-straddle
    step(1, 32'h0513_4581, 64'h1000, 0, 1, 0, 0);
    step(0, 32'h0, 64'h0, 0, 1, 0, 1);
    step(1, 32'h0001_0000, 64'h1004, 0, 1, 0, 0);
    chk("rst_a0", cap_a0, 64'h1004);
    chk("rst_i0", 64'(cap_i0), 64'h0);
    // wrap: save at the top of the address space, continue at 0
    step(1, 32'hFFFF_4581, 64'hFFFF_FFFF_FFFF_FFFC, 0, 1, 0, 0);
    step(1, 32'h0001_0000, 64'h0, 0, 1, 0, 0);
    chk("wrap_a0", cap_a0, 64'hFFFF_FFFF_FFFF_FFFE);
    // random traffic
    for (int n = 0; n < 400; n++) begin
      rd = $urandom;
      if ($urandom_range(1, 0) == 1) rd[1:0] = 2'b11;
      if ($urandom_range(1, 0) == 1) rd[17:16] = 2'b11;
      if (mq && $urandom_range(2, 0) != 0) ra = maddr + 64'd2;
      else if ($urandom_range(7, 0) == 0) ra = 64'hFFFF_FFFF_FFFF_FFFC | 64'($urandom_range(1, 0) * 2);
      else ra = {$urandom, $urandom} & ~64'h1;
      step(($urandom_range(9, 0) != 0), rd, ra, ($urandom_range(19, 0) == 0),
           ($urandom_range(9, 0) != 0), ($urandom_range(29, 0) == 0),
           ($urandom_range(49, 0) == 0));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
